dmadd_cmd_seq: RTL
==================

// Module: dmadd_cmd_seq
// PURPOSE
//  Command front-end for the delta multiply-add (DMADD) unit, directly upstream of it.
//  Accepts an 8-bit command byte stream over a valid/ready handshake and buffers it
//  in a small FIFO.
//  Decodes commands into DMADD's insn/load/index/data/run control pattern with
//  exact pulse widths, so host pins never drive DMADD timing directly.
// PARAMETERS
//  FIFO_DEPTH  4   command byte FIFO entries (power of 2, >=2)
//  RUN_W       6   width of RUN cycle count field; count 0 encodes 2**RUN_W
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  ena        in   1  design enable; low freezes all state, outputs held (load/run forced 0)
//  abort      in   1  synchronous abort, bypasses FIFO
//  cmd_byte   in   8  command byte
//  cmd_valid  in   1  cmd_byte valid
//  cmd_ready  out  1  byte accepted on edge where valid&ready
//  dm_insn    out  2  to DMADD insn (00 MIN,01 MAX,10 MADD,11 AMADD)
//  dm_load    out  1  to DMADD load
//  dm_run     out  1  to DMADD run
//  dm_index   out  4  to DMADD index
//  dm_data    out  4  to DMADD data
//  busy       out  1  FSM not IDLE or FIFO non-empty
//  done       out  1  one-cycle pulse at end of each RUN
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, all outputs 0 (dm_insn=00, cmd_ready=0 until ena).
//  Encoding [7:6]: 00 SET_INSN ([1:0]=insn); 01 LOAD ([3:0]=index, next byte [3:0]=data);
//   10 RUN ([RUN_W-1:0]=cycle count); 11 NOP (ignored, still consumed).
//  cmd_ready = ena & !full (registered count, no same-cycle push-when-full even if popping).
//  FIFO: registered read; pop only when FSM in IDLE or LOAD_WAIT and ena=1.
//  FSM states: IDLE, LOAD_WAIT, LOAD_PULSE, RUN, DONE.
//   IDLE: pop head; SET_INSN -> dm_insn updated next edge, stay IDLE; LOAD -> latch
//    index, LOAD_WAIT; RUN -> latch count, RUN; NOP -> IDLE.
//   LOAD_WAIT: pop next byte (any opcode bits ignored), latch [3:0] as data -> LOAD_PULSE.
//   LOAD_PULSE: dm_load=1 exactly one cycle, dm_index/dm_data stable that cycle -> IDLE.
//   RUN: dm_run=1 for exactly count cycles (0 -> 2**RUN_W), down-counter -> DONE.
//   DONE: done=1 one cycle, dm_run=0 -> IDLE.
//  Latency: byte accepted at edge N is decoded at edge N+1; its effect (dm_insn change,
//   dm_run rise) visible after edge N+2. dm_load rises after edge N+3 of the data byte.
//  dm_insn changes only in IDLE; held constant through LOAD_* and RUN.
//  Min one IDLE cycle (load=run=0) between consecutive LOAD/RUN ops (DMADD init window).
//  abort=1 (with ena): next edge flushes FIFO, FSM->IDLE, dm_load/dm_run=0, no done
//   pulse; dm_insn retained. abort with cmd_valid: byte dropped (cmd_ready=0 that cycle).
//  ena=0 mid-RUN: counter frozen, dm_run low; resumes remaining count when ena returns.
//  Async reset mid-RUN: dm_run drops immediately (asynchronously), pending bytes lost.
//  LOAD byte as last FIFO entry: FSM waits in LOAD_WAIT indefinitely for data byte.
// STRUCTURE
//  Package dmadd_pkg: opcode constants (OP_SET_INSN/OP_LOAD/OP_RUN/OP_NOP), insn codes,
//   FSM state enum.
//  One sub-module: dmadd_cmd_fifo (sync FIFO, async active-low reset, push/pop/full/empty,
//   registered dout). FSM, run counter, output registers in top.
// TESTING
//  1 Reset, ena=1, send 0x02 -> dm_insn=10 two cycles later, busy drops, no load/run.
//  2 Send 0x45,0x09 -> single dm_load pulse with dm_index=5, dm_data=9; no run.
//  3 Send 0x83 -> dm_run high exactly 3 cycles, done pulse next cycle; 0x80 -> 64 cycles.
//  4 Push 6 bytes back-to-back, RUN first -> cmd_ready low while 4 held, no byte lost,
//   commands execute in order with one idle cycle between ops.
//  5 abort during RUN with 0x88 -> dm_run low after next edge, no done, FIFO empty,
//   dm_insn unchanged; ena=0 mid-RUN of 0x85 -> total high cycles still 5.
//  6 rst_n low mid-RUN -> dm_run/dm_load 0 without clock edge, all outputs reset values.

Source files
------------

// File: rtl/dmadd_pkg.sv
// Shared constants and types for the DMADD command front-end.
package dmadd_pkg;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned ST_W  = 3;

  localparam logic [1:0] OP_SET_INSN = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_RUN      = 2'b10;
  localparam logic [1:0] OP_NOP      = 2'b11;

  localparam logic [1:0] INSN_MIN   = 2'b00;
  localparam logic [1:0] INSN_MAX   = 2'b01;
  localparam logic [1:0] INSN_MADD  = 2'b10;
  localparam logic [1:0] INSN_AMADD = 2'b11;

  localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD_WAIT  = 3'd1;
  localparam logic [ST_W-1:0] ST_LOAD_PULSE = 3'd2;
  localparam logic [ST_W-1:0] ST_RUN        = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE       = 3'd4;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] arg;
  } cmd_byte_t;

endpackage

// File: rtl/dmadd_cmd_fifo.sv
// Synchronous command-byte FIFO with registered read port and flush.
module dmadd_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmadd_cmd_seq.sv
// DMADD command sequencer: buffers host command bytes and replays them as
// exact-width insn/load/run control sequences toward the DMADD unit.
module dmadd_cmd_seq
  import dmadd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RUN_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       abort,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [1:0] dm_insn,
  output logic       dm_load,
  output logic       dm_run,
  output logic [3:0] dm_index,
  output logic [3:0] dm_data,
  output logic       busy,
  output logic       done
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [1:0]       insn_q, insn_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       data_q, data_d;
  logic             load_q, load_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rdy_en_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  cmd_byte_t        head;
  logic             can_take;

  assign head       = cmd_byte_t'(fifo_dout);
  assign cmd_ready  = ena & rdy_en_q & ~fifo_full & ~abort;
  assign fifo_push  = cmd_valid & cmd_ready;
  assign fifo_flush = ena & abort;
  assign can_take   = (state_q == ST_IDLE) || (state_q == ST_LOAD_WAIT);

  dmadd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (cmd_byte),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Strobes are gated by ena so a disabled design never drives load/run.
  assign dm_load  = load_q & ena;
  assign dm_run   = run_q & ena;
  assign dm_insn  = insn_q;
  assign dm_index = idx_q;
  assign dm_data  = data_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty | rd_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      insn_q   <= INSN_MIN;
      idx_q    <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      insn_q   <= insn_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      load_q   <= load_d;
      run_q    <= run_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Head byte sits in the FIFO output register (rd_vld_q) until IDLE or
  // LOAD_WAIT consumes it; those states refill it in the same cycle.
  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    idx_d    = idx_q;
    data_d   = data_q;
    load_d   = load_q;
    run_d    = run_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    rd_vld_d = rd_vld_q;
    fifo_pop = 1'b0;

    if (ena) begin
      if (abort) begin
        state_d  = ST_IDLE;
        load_d   = 1'b0;
        run_d    = 1'b0;
        done_d   = 1'b0;
        rd_vld_d = 1'b0;
      end else begin
        done_d   = 1'b0;
        fifo_pop = can_take & ~fifo_empty;
        if (can_take) rd_vld_d = fifo_pop;

        case (state_q)
          ST_IDLE: begin
            if (rd_vld_q) begin
              case (head.op)
                OP_SET_INSN: insn_d = head.arg[1:0];
                OP_LOAD: begin
                  idx_d   = head.arg[3:0];
                  state_d = ST_LOAD_WAIT;
                end
                OP_RUN: begin
                  cnt_d   = head.arg[RUN_W-1:0];
                  run_d   = 1'b1;
                  state_d = ST_RUN;
                end
                default: ;
              endcase
            end
          end
          ST_LOAD_WAIT: begin
            if (rd_vld_q) begin
              data_d  = head.arg[3:0];
              state_d = ST_LOAD_PULSE;
            end
          end
          // First cycle settles index/data, second cycle carries the pulse.
          ST_LOAD_PULSE: begin
            if (!load_q) begin
              load_d = 1'b1;
            end else begin
              load_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
          // Count 0 wraps through the full 2**RUN_W range before reaching 1.
          ST_RUN: begin
            if (cnt_q == RUN_W'(1)) begin
              run_d   = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q - RUN_W'(1);
            end
          end
          ST_DONE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

endmodule
